// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcode encodings, instruction field positions and
// the link register used by JAL.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  localparam int LINK_REG = 31;

endpackage

// File: rtl/instr_decoder.sv
// Combinational MIPS instruction decoder: source/destination register fields,
// control flags and the sign-extended immediate.
module instr_decoder
  import mips_defs::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LINK_DEST      = 31
) (
  input  logic [DATA_WIDTH-1:0]     instr,
  output logic [REG_ADDR_WIDTH-1:0] rs,
  output logic [REG_ADDR_WIDTH-1:0] rt,
  output logic [REG_ADDR_WIDTH-1:0] dest,
  output logic                      reg_write,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic                      uses_rs,
  output logic                      uses_rt,
  output logic [DATA_WIDTH-1:0]     imm
);

  logic [5:0]                opcode_s;
  logic [REG_ADDR_WIDTH-1:0] rd_s;
  logic [15:0]               imm16_s;
  logic [REG_ADDR_WIDTH-1:0] dest_s;
  logic                      reg_write_raw_s;

  assign opcode_s = instr[OPCODE_MSB:OPCODE_LSB];
  assign rs       = instr[RS_MSB:RS_LSB];
  assign rt       = instr[RT_MSB:RT_LSB];
  assign rd_s     = instr[RD_MSB:RD_LSB];
  assign imm16_s  = instr[IMM_MSB:IMM_LSB];
  assign imm      = {{(DATA_WIDTH-16){imm16_s[15]}}, imm16_s};

  // Opcode to destination/control mapping; unknown opcodes behave as NOP.
  always_comb begin
    dest_s          = '0;
    reg_write_raw_s = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    uses_rs         = 1'b0;
    uses_rt         = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        dest_s          = rd_s;
        reg_write_raw_s = 1'b1;
        uses_rs         = 1'b1;
        uses_rt         = 1'b1;
      end
      OP_ADDI, OP_XORI: begin
        dest_s          = rt;
        reg_write_raw_s = 1'b1;
        uses_rs         = 1'b1;
      end
      OP_LW: begin
        dest_s          = rt;
        reg_write_raw_s = 1'b1;
        mem_read        = 1'b1;
        uses_rs         = 1'b1;
      end
      OP_SW: begin
        mem_write = 1'b1;
        uses_rs   = 1'b1;
        uses_rt   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_J: begin
        dest_s = '0;
      end
      OP_JAL: begin
        dest_s          = REG_ADDR_WIDTH'(LINK_DEST);
        reg_write_raw_s = 1'b1;
      end
      default: begin
        dest_s          = '0;
        reg_write_raw_s = 1'b0;
      end
    endcase
  end

  // Writing $0 is architecturally a no-op, so suppress it at the source.
  assign dest      = dest_s;
  assign reg_write = reg_write_raw_s && (dest_s != '0);

endmodule

// File: rtl/id_operand_stage.sv
// Decode / operand-fetch stage: drives regfile read addresses, bypasses the
// same-edge write-back, detects load-use hazards and holds the ID/EX register.
module id_operand_stage
  import mips_defs::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LINK_REG       = mips_defs::LINK_REG
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [DATA_WIDTH-1:0]     Instr,
  input  logic [DATA_WIDTH-1:0]     InPC,
  output logic [REG_ADDR_WIDTH-1:0] ReadRegister1,
  output logic [REG_ADDR_WIDTH-1:0] ReadRegister2,
  input  logic [DATA_WIDTH-1:0]     ReadData1,
  input  logic [DATA_WIDTH-1:0]     ReadData2,
  input  logic                      WbRegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] WbReg,
  input  logic [DATA_WIDTH-1:0]     WbData,
  input  logic                      Flush,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [DATA_WIDTH-1:0]     OutOp1,
  output logic [DATA_WIDTH-1:0]     OutOp2,
  output logic [DATA_WIDTH-1:0]     OutImm,
  output logic [REG_ADDR_WIDTH-1:0] OutDest,
  output logic                      OutRegWrite,
  output logic                      OutMemRead,
  output logic                      OutMemWrite,
  output logic [5:0]                OutOpcode,
  output logic [5:0]                OutFunct,
  output logic [DATA_WIDTH-1:0]     OutPC
);

  logic [REG_ADDR_WIDTH-1:0] rs_s;
  logic [REG_ADDR_WIDTH-1:0] rt_s;
  logic [REG_ADDR_WIDTH-1:0] dest_s;
  logic                      reg_write_s;
  logic                      mem_read_s;
  logic                      mem_write_s;
  logic                      uses_rs_s;
  logic                      uses_rt_s;
  logic [DATA_WIDTH-1:0]     imm_s;
  logic [DATA_WIDTH-1:0]     op1_s;
  logic [DATA_WIDTH-1:0]     op2_s;
  logic                      hazard_s;
  logic                      in_ready_s;
  logic                      accept_s;

  instr_decoder #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .LINK_DEST      (LINK_REG)
  ) u_decoder (
    .instr     (Instr),
    .rs        (rs_s),
    .rt        (rt_s),
    .dest      (dest_s),
    .reg_write (reg_write_s),
    .mem_read  (mem_read_s),
    .mem_write (mem_write_s),
    .uses_rs   (uses_rs_s),
    .uses_rt   (uses_rt_s),
    .imm       (imm_s)
  );

  // The regfile write lands on the capture edge, so forward it here; $0 reads 0.
  function automatic logic [DATA_WIDTH-1:0] pick_operand(
    input logic [REG_ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0]     rdata,
    input logic                      wb_we,
    input logic [REG_ADDR_WIDTH-1:0] wb_reg,
    input logic [DATA_WIDTH-1:0]     wb_data
  );
    logic [DATA_WIDTH-1:0] result;
    if (addr == '0) begin
      result = '0;
    end else if (wb_we && (wb_reg == addr)) begin
      result = wb_data;
    end else begin
      result = rdata;
    end
    return result;
  endfunction

  assign ReadRegister1 = rs_s;
  assign ReadRegister2 = rt_s;

  assign op1_s = pick_operand(rs_s, ReadData1, WbRegWrite, WbReg, WbData);
  assign op2_s = pick_operand(rt_s, ReadData2, WbRegWrite, WbReg, WbData);

  // A held load whose target is a source of the incoming instruction stalls it.
  assign hazard_s = OutValid && OutMemRead && (OutDest != '0) &&
                    ((uses_rs_s && (OutDest == rs_s)) ||
                     (uses_rt_s && (OutDest == rt_s)));

  assign in_ready_s = Flush || (!hazard_s && (!OutValid || OutReady));
  assign accept_s   = InValid && in_ready_s;
  assign InReady    = in_ready_s;

  // ID/EX pipeline register: flush, capture, drain to bubble, else hold.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      OutValid    <= 1'b0;
      OutOp1      <= '0;
      OutOp2      <= '0;
      OutImm      <= '0;
      OutDest     <= '0;
      OutRegWrite <= 1'b0;
      OutMemRead  <= 1'b0;
      OutMemWrite <= 1'b0;
      OutOpcode   <= 6'd0;
      OutFunct    <= 6'd0;
      OutPC       <= '0;
    end else if (Flush) begin
      OutValid <= 1'b0;
    end else if (accept_s) begin
      OutValid    <= 1'b1;
      OutOp1      <= op1_s;
      OutOp2      <= op2_s;
      OutImm      <= imm_s;
      OutDest     <= dest_s;
      OutRegWrite <= reg_write_s;
      OutMemRead  <= mem_read_s;
      OutMemWrite <= mem_write_s;
      OutOpcode   <= Instr[OPCODE_MSB:OPCODE_LSB];
      OutFunct    <= Instr[FUNCT_MSB:FUNCT_LSB];
      OutPC       <= InPC;
    end else if (OutValid && OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule
